aes_chip_link: RTL and testbench

Chip-side end of the 9-bit byte-serial link used to move AES blocks between the verify platform and the chip. It receives 128-bit blocks as 16 bytes qualified by a toggling shakehand, and presents each block to the AES core on a valid/ready port. It accepts 128-bit results from the core and sends them back as 16 shakehand-qualified bytes, paced by a programmable byte period. It sits between the chip pads (`aes_tx[8:0]` from the platform, `aes_rx[8:0]` to the platform) and the AES core, in the chip clock domain.

---
 rtl/aes_chip_link_if.sv | 21 ++
 rtl/aes_chip_link.sv | 146 ++++++++++++++
 tb/tb_aes_chip_link.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_chip_link_if.sv
// Core-side block ports of aes_chip_link: inbound block (valid/ready) and outbound result (valid/ready).
interface aes_chip_link_if;
    localparam int unsigned BLK_W = 128;

    logic [BLK_W-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [BLK_W-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    // master: the link block; slave: the AES core side
    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );
    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );
endinterface

// File: rtl/aes_chip_link.sv
// Chip-side end of the 9-bit byte-serial AES link: assembles 16 inbound bytes into a block
// for the core and serialises core results back out at a programmable byte period.
module aes_chip_link #(
    parameter int unsigned TX_DIV   = 8,
    parameter int unsigned TX_SETUP = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx_shakehand,
    input  logic [7:0]            rx,
    aes_chip_link_if.master       core,
    output logic                  tx_shakehand,
    output logic [7:0]            tx,
    output logic                  rx_overrun
);
    localparam int unsigned BLK_W  = 128;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned NBYTES = 16;
    localparam int unsigned CNT_W  = 5;
    localparam int unsigned TMR_W  = 8;

    // ---------------- RX path ----------------
    logic              sh1, sh2, sh3;
    logic [BYTE_W-1:0] rx_q;
    logic [1:0]        arm_cnt;
    logic [BLK_W-1:0]  asm_q;
    logic [CNT_W-1:0]  rx_cnt;

    logic rx_edge_c, pending_c, take_c, armed_c;

    // Ignore edges while the synchronizer fills, so a high line level at reset is not a byte
    assign armed_c   = (arm_cnt == 2'd3);
    assign rx_edge_c = (sh2 ^ sh3) & armed_c;
    assign pending_c = (rx_cnt == CNT_W'(NBYTES));
    assign take_c    = core.in_valid & core.in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sh1           <= 1'b0;
            sh2           <= 1'b0;
            sh3           <= 1'b0;
            rx_q          <= '0;
            arm_cnt       <= '0;
            asm_q         <= '0;
            rx_cnt        <= '0;
            core.in_data  <= '0;
            core.in_valid <= 1'b0;
            rx_overrun    <= 1'b0;
        end else begin
            sh1  <= rx_shakehand;
            sh2  <= sh1;
            sh3  <= sh2;
            rx_q <= rx;
            if (!armed_c) arm_cnt <= arm_cnt + 2'd1;

            if (rx_edge_c) begin
                if (pending_c) begin
                    rx_overrun <= 1'b1;
                end else begin
                    asm_q  <= {asm_q[BLK_W-BYTE_W-1:0], rx_q};
                    rx_cnt <= rx_cnt + CNT_W'(1);
                end
            end

            if (take_c) core.in_valid <= 1'b0;
            // Refill on the same edge the core takes the held block
            if (pending_c && (!core.in_valid || take_c)) begin
                core.in_data  <= asm_q;
                core.in_valid <= 1'b1;
                rx_cnt        <= '0;
            end
        end
    end

    // ---------------- TX path ----------------
    typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;

    tx_state_t         state_q, state_d;
    logic [BLK_W-1:0]  tsr_q, tsr_d;
    logic [BYTE_W-1:0] tx_d;
    logic [3:0]        tx_cnt_q, tx_cnt_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic              tsh_d;
    logic              out_ready_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= TX_IDLE;
            tsr_q          <= '0;
            tx             <= '0;
            tx_cnt_q       <= '0;
            timer_q        <= '0;
            tx_shakehand   <= 1'b0;
            core.out_ready <= 1'b1;
        end else begin
            state_q        <= state_d;
            tsr_q          <= tsr_d;
            tx             <= tx_d;
            tx_cnt_q       <= tx_cnt_d;
            timer_q        <= timer_d;
            tx_shakehand   <= tsh_d;
            core.out_ready <= out_ready_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        tsr_d       = tsr_q;
        tx_d        = tx;
        tx_cnt_d    = tx_cnt_q;
        timer_d     = timer_q;
        tsh_d       = tx_shakehand;
        out_ready_d = core.out_ready;

        unique case (state_q)
            TX_IDLE: begin
                out_ready_d = 1'b1;
                if (core.out_valid) begin
                    tsr_d       = core.out_data;
                    tx_d        = core.out_data[BLK_W-1 -: BYTE_W];
                    tx_cnt_d    = '0;
                    timer_d     = '0;
                    out_ready_d = 1'b0;
                    state_d     = TX_SEND;
                end
            end
            TX_SEND: begin
                out_ready_d = 1'b0;
                timer_d     = timer_q + TMR_W'(1);
                if (timer_q == TMR_W'(TX_SETUP - 1)) tsh_d = ~tx_shakehand;
                if (timer_q == TMR_W'(TX_DIV - 1)) begin
                    timer_d = '0;
                    if (tx_cnt_q == 4'(NBYTES - 1)) begin
                        out_ready_d = 1'b1;
                        state_d     = TX_IDLE;
                    end else begin
                        tsr_d    = {tsr_q[BLK_W-BYTE_W-1:0], BYTE_W'(0)};
                        tx_d     = tsr_q[BLK_W-BYTE_W-1 -: BYTE_W];
                        tx_cnt_d = tx_cnt_q + 4'd1;
                    end
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end
endmodule

// File: tb/tb_aes_chip_link.sv
// Scoreboard bench for aes_chip_link: directed RX/TX blocks, backpressure, loopback and reset cases.
module tb_aes_chip_link;
    localparam int unsigned TX_DIV   = 8;
    localparam int unsigned TX_SETUP = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        drv_sh = 1'b0;
    logic [7:0]  drv_rx = 8'h00;
    logic        loop_en = 1'b0;
    logic        rx_shakehand;
    logic [7:0]  rx;
    logic        tx_shakehand;
    logic [7:0]  tx;
    logic        rx_overrun;

    assign rx_shakehand = loop_en ? tx_shakehand : drv_sh;
    assign rx           = loop_en ? tx : drv_rx;

    aes_chip_link_if bus ();

    aes_chip_link #(.TX_DIV(TX_DIV), .TX_SETUP(TX_SETUP)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_shakehand (rx_shakehand),
        .rx           (rx),
        .core         (bus),
        .tx_shakehand (tx_shakehand),
        .tx           (tx),
        .rx_overrun   (rx_overrun)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_pass = 0;
    logic [127:0] rx_exp[$];
    logic [127:0] tx_exp[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    // RX monitor: every block the core takes must match the next expected block
    always @(negedge clk) begin
        if (rst_n && bus.in_valid && bus.in_ready) begin
            if (rx_exp.size() == 0) begin
                n_chk++;
                $display("FAIL rx_unexpected: got %h want none", bus.in_data);
            end else begin
                check("rx_block", bus.in_data, rx_exp.pop_front());
            end
        end
    end

    // TX monitor: accept edge, byte values, toggle timing, ready return
    logic         t_act = 1'b0;
    int unsigned  a_edge = 0;
    int           k = 0;
    logic [127:0] cur = '0;
    logic         p_ov = 1'b0, p_or = 1'b0, p_tsh = 1'b0, p_rst = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            t_act = 1'b0;
        end else begin
            if (t_act && (tx_shakehand !== p_tsh)) begin
                if (k < 16) begin
                    check("tx_byte", 128'(tx), 128'(cur[127-8*k -: 8]));
                    check("tx_toggle_time", 128'(cyc), 128'(a_edge + k*TX_DIV + TX_SETUP));
                    k++;
                end else begin
                    n_chk++;
                    $display("FAIL tx_extra_toggle: got toggle at %0d want none", cyc);
                end
            end
            if (t_act && k == 16 && bus.out_ready) begin
                check("tx_ready_time", 128'(cyc), 128'(a_edge + 16*TX_DIV));
                t_act = 1'b0;
            end
            if (p_ov && p_or && p_rst) begin
                if (tx_exp.size() == 0) begin
                    n_chk++;
                    $display("FAIL tx_unexpected_accept: got accept at %0d want none", cyc);
                end else begin
                    cur    = tx_exp.pop_front();
                    a_edge = cyc;
                    k      = 0;
                    t_act  = 1'b1;
                    check("tx_first_byte", 128'(tx), 128'(cur[127:120]));
                end
            end
        end
        p_ov  = bus.out_valid;
        p_or  = bus.out_ready;
        p_tsh = tx_shakehand;
        p_rst = rst_n;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        drv_rx = b;
        tick(1);
        drv_sh = ~drv_sh;
        tick(5);
    endtask

    task automatic send_block(input logic [127:0] blk);
        for (int i = 0; i < 16; i++) send_byte(blk[127-8*i -: 8]);
    endtask

    task automatic do_reset(input logic sh_level);
        rst_n  = 1'b0;
        drv_sh = sh_level;
        tick(3);
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_data"},   bus.in_data, 128'h0);
        check({tag, "_in_valid"},  128'(bus.in_valid), 128'h0);
        check({tag, "_out_ready"}, 128'(bus.out_ready), 128'h1);
        check({tag, "_tx_sh"},     128'(tx_shakehand), 128'h0);
        check({tag, "_tx"},        128'(tx), 128'h0);
        check({tag, "_overrun"},   128'(rx_overrun), 128'h0);
    endtask

    task automatic wait_ready(input logic lvl, input int lim, input string name);
        for (int i = 0; i < lim && bus.out_ready !== lvl; i++) tick(1);
        check(name, 128'(bus.out_ready), 128'(lvl));
    endtask

    task automatic offer_tx(input logic [127:0] blk);
        tx_exp.push_back(blk);
        bus.out_data  = blk;
        bus.out_valid = 1'b1;
        wait_ready(1'b0, 5, "tx_accept");
        bus.out_valid = 1'b0;
    endtask

    initial begin
        logic [127:0] blk_a, blk_b, blk;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_data  = '0;

        do_reset(1'b0);
        check_reset_vals("rst");

        // Single RX block
        bus.in_ready = 1'b1;
        blk = 128'h000102030405060708090a0b0c0d0e0f;
        rx_exp.push_back(blk);
        send_block(blk);
        tick(10);
        check("t1_drained", 128'(rx_exp.size()), 128'h0);
        check("t1_overrun", 128'(rx_overrun), 128'h0);

        // Backpressure and overrun
        bus.in_ready = 1'b0;
        blk_a = 128'h11223344_55667788_99aabbcc_ddeeff00;
        blk_b = 128'hfedcba98_76543210_0f1e2d3c_4b5a6978;
        send_block(blk_a);
        send_block(blk_b);
        tick(6);
        check("t2_hold_valid", 128'(bus.in_valid), 128'h1);
        check("t2_hold_data", bus.in_data, blk_a);
        check("t2_no_overrun_yet", 128'(rx_overrun), 128'h0);
        send_byte(8'h5a);
        tick(4);
        check("t2_overrun", 128'(rx_overrun), 128'h1);
        check("t2_still_a", bus.in_data, blk_a);
        rx_exp.push_back(blk_a);
        rx_exp.push_back(blk_b);
        bus.in_ready = 1'b1;
        tick(1);
        check("t2_refill_valid", 128'(bus.in_valid), 128'h1);
        check("t2_refill_data", bus.in_data, blk_b);
        tick(3);
        check("t2_drained", 128'(rx_exp.size()), 128'h0);
        check("t2_valid_low", 128'(bus.in_valid), 128'h0);

        // Single TX block
        do_reset(1'b0);
        check_reset_vals("rst2");
        offer_tx(128'hab7240f9_c5e0bb5e_ee8e34b6_bb84cfb0);
        wait_ready(1'b1, 300, "t3_ready_back");
        tick(2);
        check("t3_tx_hold", 128'(tx), 128'hb0);
        check("t3_tx_sh_even", 128'(tx_shakehand), 128'h0);

        // Loopback of 100 blocks
        bus.in_ready = 1'b1;
        loop_en = 1'b1;
        for (int n = 0; n < 100; n++) begin
            blk = {$urandom, $urandom, $urandom, $urandom};
            rx_exp.push_back(blk);
            offer_tx(blk);
            wait_ready(1'b1, 300, "t4_ready_back");
        end
        tick(10);
        check("t4_rx_drained", 128'(rx_exp.size()), 128'h0);
        check("t4_overrun", 128'(rx_overrun), 128'h0);
        loop_en = 1'b0;

        // High shakehand level through reset must not count as a byte
        do_reset(1'b1);
        tick(10);
        check("t5_no_valid", 128'(bus.in_valid), 128'h0);
        blk = 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;
        rx_exp.push_back(blk);
        send_block(blk);
        tick(10);
        check("t5_drained", 128'(rx_exp.size()), 128'h0);

        // Reset in the middle of a TX and an RX block
        offer_tx(128'h55aa55aa_00ff00ff_12345678_9abcdef0);
        for (int i = 0; i < 5; i++) send_byte(8'(8'hc0 + i));
        do_reset(drv_sh);
        check_reset_vals("rst3");
        blk = 128'hdeadbeef_cafef00d_01234567_89abcdef;
        rx_exp.push_back(blk);
        send_block(blk);
        tick(10);
        check("t6_drained", 128'(rx_exp.size()), 128'h0);
        check("t6_tx_q", 128'(tx_exp.size()), 128'h0);
        check("t6_overrun", 128'(rx_overrun), 128'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule
